// File: rtl/cnn_mem_pkg.sv
// Shared constants and types for the CNN accelerator weight memory path.
package cnn_mem_pkg;
  localparam int unsigned CNN_DATA_W = 72;
  localparam int unsigned CNN_ADDR_W = 10;
  localparam int unsigned CNN_DEPTH  = 576;
  localparam int unsigned WORDS_FW   = 3;
  localparam int unsigned ITEMS_FW   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LAST  = 2'd2
  } wfs_state_e;
endpackage

// File: rtl/sadslspkb1p576x72m4b1w0cp0d0t0.sv
// Behavioural model of the 576x72 single-port weight SRAM macro.
// Read latency 1 cycle; Q holds its value on write and idle cycles.
module sadslspkb1p576x72m4b1w0cp0d0t0 (
  input  logic        CLK,
  input  logic        ME,
  input  logic        WE,
  input  logic [9:0]  ADR,
  input  logic [71:0] D,
  output logic [71:0] Q
);
  logic [71:0] mem [0:575];

  always_ff @(posedge CLK) begin
    if (ME) begin
      if (WE) mem[ADR] <= D;
      else    Q <= mem[ADR];
    end
  end
endmodule

// File: rtl/wfs_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted requester.
module wfs_rr_arb #(
  parameter int unsigned N_LAYER = 4,
  parameter int unsigned IW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LAYER-1:0] req,
  input  logic               upd,
  output logic [N_LAYER-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);
  logic [IW-1:0] start_q, start_d;

  always_comb begin : p_sel
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < N_LAYER; off++) begin
      idx = (int'(start_q) + off) % N_LAYER;
      if (!found && req[IW'(idx)]) begin
        found           = 1'b1;
        gnt[IW'(idx)]   = 1'b1;
        gnt_idx         = IW'(idx);
      end
    end
    start_d = start_q;
    if (upd) start_d = (gnt_idx == IW'(N_LAYER - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q <= '0;
    else     start_q <= start_d;
  end
endmodule

// File: rtl/weight_fetch_sched.sv
// Weight/bias fetch scheduler sharing the weight SRAM between host writes and N_LAYER consumers.
// Optional WFS_PREFETCH_EN: an acked layer (req high at ack) is re-requested automatically.
module weight_fetch_sched
  import cnn_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = CNN_DATA_W,
  parameter int unsigned ADDR_W    = CNN_ADDR_W,
  parameter int unsigned DEPTH     = CNN_DEPTH,
  parameter int unsigned N_LAYER   = 4,
  parameter int unsigned MAX_WORDS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  write_en,
  input  logic [ADDR_W-1:0]                     addr_w,
  input  logic [DATA_W-1:0]                     data_w,
  input  logic                                  en,
  input  logic                                  ptr_clr,
  input  logic [N_LAYER*ADDR_W-1:0]             cfg_base,
  input  logic [N_LAYER*WORDS_FW-1:0]           cfg_words,
  input  logic [N_LAYER*ITEMS_FW-1:0]           cfg_items,
  input  logic [N_LAYER-1:0]                    req,
  output logic [N_LAYER-1:0]                    vld,
  input  logic [N_LAYER-1:0]                    ack,
  output logic [N_LAYER*MAX_WORDS*DATA_W-1:0]   item_data,
  output logic [N_LAYER*ITEMS_FW-1:0]           item_idx,
  output logic                                  busy,
  output logic                                  addr_err
);
  localparam int unsigned WW     = WORDS_FW;
  localparam int unsigned IFW    = ITEMS_FW;
  localparam int unsigned IW     = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam int unsigned ITEM_W = MAX_WORDS * DATA_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  wfs_state_e          state_q, state_d;
  logic [IW-1:0]       g_q, g_d, gnt_idx;
  logic [WW-1:0]       k_q, k_d, cap_k_q, cap_k_d;
  logic                cap_q, cap_d, cap_zero_q, cap_zero_d;
  logic                clr_pend_q, clr_pend_d, addr_err_q, addr_err_d, busy_q, busy_d;
  logic [ITEM_W-1:0]   asm_q, asm_d;
  logic [N_LAYER-1:0]  vld_q, vld_d, elig, gnt, req_eff;
  logic [ADDR_W-1:0]   ptr_q [N_LAYER];
  logic [ADDR_W-1:0]   ptr_d [N_LAYER];
  logic [ADDR_W-1:0]   cfg_base_a [N_LAYER];
  logic [WW-1:0]       cfg_words_a [N_LAYER];
  logic [IFW-1:0]      cfg_items_a [N_LAYER];
  logic [IFW-1:0]      cnt_q [N_LAYER];
  logic [IFW-1:0]      cnt_d [N_LAYER];
  logic [IFW-1:0]      item_idx_q [N_LAYER];
  logic [IFW-1:0]      item_idx_d [N_LAYER];
  logic [ITEM_W-1:0]   item_data_q [N_LAYER];
  logic [ITEM_W-1:0]   item_data_d [N_LAYER];
  logic                arb_upd, rd_issue, rd_bad, sram_me, sram_we;
  logic [ADDR_W:0]     rd_addr;
  logic [ADDR_W-1:0]   sram_adr;
  logic [DATA_W-1:0]   sram_q, word_in;

  always_comb begin
    for (int unsigned i = 0; i < N_LAYER; i++) begin
      cfg_base_a[i]  = cfg_base[i*ADDR_W +: ADDR_W];
      cfg_words_a[i] = cfg_words[i*WW +: WW];
      cfg_items_a[i] = cfg_items[i*IFW +: IFW];
      item_data[i*ITEM_W +: ITEM_W] = item_data_q[i];
      item_idx[i*IFW +: IFW]        = item_idx_q[i];
    end
  end

`ifdef WFS_PREFETCH_EN
  logic [N_LAYER-1:0] auto_q, auto_d;

  always_comb begin
    auto_d = auto_q;
    for (int unsigned i = 0; i < N_LAYER; i++)
      if (ack[i] && vld_q[i] && req[i]) auto_d[i] = 1'b1;
    if (arb_upd) auto_d = auto_d & ~gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) auto_q <= '0;
    else     auto_q <= auto_d;
  end

  assign req_eff = req | auto_q;
`else
  assign req_eff = req;
`endif

  always_comb begin
    for (int unsigned i = 0; i < N_LAYER; i++)
      elig[i] = req_eff[i] & ~vld_q[i] & en & ~write_en & (state_q == IDLE);
  end

  wfs_rr_arb #(.N_LAYER(N_LAYER), .IW(IW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (elig),
    .upd     (arb_upd),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Extra top bit catches pointer+offset overflow as well as the DEPTH limit.
  assign rd_addr  = {1'b0, ptr_q[g_q]} + {{(ADDR_W + 1 - WW){1'b0}}, k_q};
  assign rd_bad   = (rd_addr >= DEPTH_L);
  assign sram_me  = write_en | rd_issue;
  assign sram_we  = write_en;
  assign sram_adr = write_en ? addr_w : rd_addr[ADDR_W-1:0];
  assign word_in  = cap_zero_q ? '0 : sram_q;

  sadslspkb1p576x72m4b1w0cp0d0t0 u_sram (
    .CLK (clk),
    .ME  (sram_me),
    .WE  (sram_we),
    .ADR (sram_adr),
    .D   (data_w),
    .Q   (sram_q)
  );

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    k_d         = k_q;
    cap_d       = 1'b0;
    cap_k_d     = cap_k_q;
    cap_zero_d  = 1'b0;
    clr_pend_d  = clr_pend_q;
    addr_err_d  = addr_err_q;
    asm_d       = asm_q;
    vld_d       = vld_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    item_idx_d  = item_idx_q;
    item_data_d = item_data_q;
    arb_upd     = 1'b0;
    rd_issue    = 1'b0;

    for (int unsigned i = 0; i < N_LAYER; i++)
      if (ack[i] && vld_q[i]) vld_d[i] = 1'b0;

    // Word issued last cycle; SRAM output is held across write cycles, so capture is unconditional.
    for (int unsigned w = 0; w < MAX_WORDS; w++)
      if (cap_q && cap_k_q == WW'(w)) asm_d[w*DATA_W +: DATA_W] = word_in;

    case (state_q)
      IDLE: begin
        if (ptr_clr || clr_pend_q) begin
          clr_pend_d = 1'b0;
          for (int unsigned i = 0; i < N_LAYER; i++) begin
            ptr_d[i] = cfg_base_a[i];
            cnt_d[i] = '0;
          end
        end
        if (|gnt) begin
          arb_upd = 1'b1;
          g_d     = gnt_idx;
          k_d     = '0;
          asm_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ptr_clr) clr_pend_d = 1'b1;
        if (!write_en) begin
          rd_issue   = ~rd_bad;
          cap_d      = 1'b1;
          cap_k_d    = k_q;
          cap_zero_d = rd_bad;
          if (rd_bad) addr_err_d = 1'b1;
          k_d = k_q + 1'b1;
          if (k_q == cfg_words_a[g_q] - 1'b1) state_d = LAST;
        end
      end
      LAST: begin
        if (ptr_clr) clr_pend_d = 1'b1;
        vld_d[g_q]       = 1'b1;
        item_data_d[g_q] = asm_d;
        item_idx_d[g_q]  = cnt_q[g_q];
        if (cnt_q[g_q] == cfg_items_a[g_q] - 1'b1) begin
          cnt_d[g_q] = '0;
          ptr_d[g_q] = cfg_base_a[g_q];
        end else begin
          cnt_d[g_q] = cnt_q[g_q] + 1'b1;
          ptr_d[g_q] = ptr_q[g_q] + {{(ADDR_W - WW){1'b0}}, cfg_words_a[g_q]};
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      g_q        <= '0;
      k_q        <= '0;
      cap_q      <= 1'b0;
      cap_k_q    <= '0;
      cap_zero_q <= 1'b0;
      clr_pend_q <= 1'b0;
      addr_err_q <= 1'b0;
      busy_q     <= 1'b0;
      asm_q      <= '0;
      vld_q      <= '0;
      for (int unsigned i = 0; i < N_LAYER; i++) begin
        ptr_q[i]       <= '0;
        cnt_q[i]       <= '0;
        item_idx_q[i]  <= '0;
        item_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      k_q         <= k_d;
      cap_q       <= cap_d;
      cap_k_q     <= cap_k_d;
      cap_zero_q  <= cap_zero_d;
      clr_pend_q  <= clr_pend_d;
      addr_err_q  <= addr_err_d;
      busy_q      <= busy_d;
      asm_q       <= asm_d;
      vld_q       <= vld_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      item_idx_q  <= item_idx_d;
      item_data_q <= item_data_d;
    end
  end

  assign vld      = vld_q;
  assign busy     = busy_q;
  assign addr_err = addr_err_q;
endmodule

// File: doc/weight_fetch_sched.md
# weight_fetch_sched

Parametrised weight/bias fetch scheduler for the CNN accelerator. It owns the single-port weight SRAM and shares it between a host write path and N_LAYER compute layers. Each layer requests one "item" (one kernel's weight and bias words) through a valid/ack handshake. A round-robin arbiter serves the layers, and per-layer pointers walk the layer's SRAM region with wrap-around. It replaces fixed-schedule fetch logic that was hard-coded to one network shape.

## Interface
- DATA_W, 72: SRAM word width.
- ADDR_W, 10: SRAM address width.
- DEPTH, 576: SRAM words; addresses >= DEPTH are illegal.
- N_LAYER, 4: number of consumer layers.
- MAX_WORDS, 4: maximum SRAM words per item.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_en  in  1  host write strobe.
- addr_w  in  ADDR_W  host write address.
- data_w  in  DATA_W  host write data.
- en  in  1  fetch enable; 0 blocks new grants, in-flight fetch completes.
- ptr_clr  in  1  pulse: reload every pointer to its base and item count to 0.
- cfg_base  in  N_LAYER*ADDR_W  region base per layer.
- cfg_words  in  N_LAYER*3  words per item per layer, range 1..MAX_WORDS.
- cfg_items  in  N_LAYER*6  items per layer, range 1..63.
- req  in  N_LAYER  per-layer fetch request (level).
- vld  out  N_LAYER  per-layer item-ready.
- ack  in  N_LAYER  per-layer consume strobe.
- item_data  out  N_LAYER*MAX_WORDS*DATA_W  per-layer assembled item.
- item_idx  out  N_LAYER*6  index of the held item.
- busy  out  1  fetch in flight.
- addr_err  out  1  sticky: generated read address >= DEPTH.

## Operation
- SRAM control: ME = write_en | read_issue; WE = write_en. The host write always wins. A read slot that collides with a write is deferred one cycle.
- Layer i is eligible when req[i] & !vld[i] & en & !write_en. Round-robin grant starts at the layer after the last granted one.
- FSM states:
  - IDLE: on any eligible layer, latch grant g and go to ISSUE.
  - ISSUE: issue address ptr[g]+k for k = 0..cfg_words[g]-1, one per non-write cycle. After the last issue go to LAST.
  - LAST: capture the final word, then go to IDLE.
- Read latency is 1 cycle. Word k is written to item_data[g][k*DATA_W +: DATA_W]. Words at or above cfg_words are zero.
- On capture of the last word:
  - vld[g] is set and item_idx[g] is loaded.
  - ptr[g] advances by cfg_words[g].
  - cnt[g] increments. When cnt reaches cfg_items-1 it wraps to 0 and ptr[g] reloads to cfg_base[g].
- item_data[g] and item_idx[g] hold stable while vld[g] is high. ack[i] & vld[i] clears vld[i] on the next edge. ack without vld is ignored.
- ptr_clr takes effect in IDLE only. If it arrives while busy, it is held pending until the FSM returns to IDLE.
- Configuration inputs must stay static while busy.
- Address arithmetic is ADDR_W+1 bits wide. An overflow or an address >= DEPTH sets addr_err; the read is suppressed (ME=0) and that word returns zero. Only rst clears addr_err.
- Reset values: vld=0, item_data=0, item_idx=0, busy=0, addr_err=0, state=IDLE, ptr=0, cnt=0. The round-robin pointer resets to layer 0. The first fetch after reset requires ptr_clr to load the bases.

## Timing
- Cycle 0: req[i] sampled high in IDLE with no write. Cycles 1..W: addresses issued. vld[i] rises at the edge ending cycle W+1. Total latency W+1 cycles.
- Each write_en cycle during ISSUE adds exactly one cycle.
- Back-to-back grants are possible: LAST→IDLE→ISSUE, with one idle cycle between fetches.
- If ack[i] and req[i] are both high in the same cycle, vld[i] clears first. The layer becomes eligible one cycle later.
- rst mid-fetch aborts the fetch. No vld is produced and the pointers are lost.

## Configuration
- WFS_PREFETCH_EN defined: a layer whose item is acked is auto-requested. Its next fetch is eligible without req, as long as req was high at the ack.
- WFS_PREFETCH_EN undefined: fetches occur only while req is high.

## Structure
- Package cnn_mem_pkg holds:
  - the DATA_W, ADDR_W and DEPTH defaults;
  - the FSM state typedef (IDLE/ISSUE/LAST);
  - the cfg_words and cfg_items field widths.
- Sub-module wfs_rr_arb: N_LAYER-wide round-robin arbiter with a one-hot grant and an update-on-grant pointer.
- The SRAM macro sadslspkb1p576x72m4b1w0cp0d0t0 is instantiated directly inside the block.

## Test plan
- Back-to-back requests from one layer: base=288, words=2, items=32, ptr_clr, req[1] held high. Required: reads 288,289 then 290,291; vld each 3 cycles after grant; item_idx 0,1,…; after idx 31, the next address is 288.
- Layers 0 and 2 request simultaneously: grants alternate 0,2,0,2 and no layer is starved.
- write_en pulsed during ISSUE: the write lands at addr_w, the read slot slips one cycle, vld is delayed by 1, and the data equals the words written earlier.
- Hold-until-ack: hold ack low for 10 cycles. vld and data are stable and no refetch occurs; WFS_PREFETCH_EN changes only the refetch timing after ack.
- Address range: base=574, words=4, so address 576 is reached. addr_err goes to 1 and the upper words read as zero.
- rst asserted mid-ISSUE: all outputs return to zero immediately and the FSM is in IDLE.
